// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the pipeline hazard controller
package hazard_pkg;

    // Operand forwarding source select
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // ResultSrcE encoding that marks a load in Execute
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    // Memory-wait FSM
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_if.sv
// rtl/hazard_if.sv - data-memory handshake seen by the hazard controller
interface hazard_if;
    logic MemReqM;
    logic MemReadyM;

    modport master (output MemReqM, output MemReadyM);
    modport slave  (input  MemReqM, input  MemReadyM);
endinterface

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - forwarding select for one Execute source operand
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);

    // Memory stage is younger than Writeback, so it wins; x0 is never forwarded
    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e))
            fwd = FWD_MEM;
        else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e))
            fwd = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, stall/flush, memory-wait FSM and perf counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [1:0]  ResultSrcE,
    input  logic        PCSrcE,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteW,
    hazard_if.slave     mem,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MemErr,
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt
);

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    hz_state_e  state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_nxt;
    logic       mem_wait;
    logic       load_use;

    fwd_unit u_fwd_a (
        .rs_e        (Rs1E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .fwd         (ForwardAE)
    );

    fwd_unit u_fwd_b (
        .rs_e        (Rs2E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .fwd         (ForwardBE)
    );

    assign mem_wait = mem.MemReqM && !mem.MemReadyM;
    assign load_use = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    // Stall/flush priority: reset bubbles, then memory wait freezes all, then branch over load-use
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (mem_wait) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = load_use && !PCSrcE;
            StallD = load_use && !PCSrcE;
            FlushD = PCSrcE;
            FlushE = PCSrcE || load_use;
        end
    end

    // Wait counter saturates at the timeout so MemErr can't be re-evaluated past it
    always_comb begin
        wait_nxt = wait_cnt;
        if (wait_cnt != TIMEOUT)
            wait_nxt = wait_cnt + 8'd1;
    end

    // Memory-wait FSM, timeout detection and performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            MemErr   <= 1'b0;
            StallCnt <= 32'd0;
            FlushCnt <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    wait_cnt <= 8'd0;
                    if (mem_wait)
                        state <= MEM_WAIT;
                end
                default: begin
                    wait_cnt <= wait_nxt;
                    if (wait_nxt == TIMEOUT)
                        MemErr <= 1'b1;
                    if (mem.MemReadyM)
                        state <= RUN;
                end
            endcase
            StallCnt <= StallCnt + {31'd0, StallF};
            FlushCnt <= FlushCnt + {31'd0, FlushE};
        end
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, meaning the number of data-memory wait cycles after which MemErr is raised (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have ports Rs1D and Rs2D, each input, 5, source registers of the instruction in Decode.
REQ-005 SHALL have ports Rs1E, Rs2E and RdE, each input, 5, source and destination registers of the instruction in Execute.
REQ-006 SHALL have port ResultSrcE, input, 2, result select of Execute; 2'b01 marks a load.
REQ-007 SHALL have port PCSrcE, input, 1, taken branch or jump resolved in Execute.
REQ-008 SHALL have ports RdM and RegWriteM, input, 5 and 1, destination and write enable in Memory.
REQ-009 SHALL have ports RdW and RegWriteW, input, 5 and 1, destination and write enable in Writeback.
REQ-010 SHALL have ports MemReqM and MemReadyM, input, 1 each, data-memory access request and completion.
REQ-011 SHALL have ports ForwardAE and ForwardBE, output, 2 each: 00 register file, 01 Writeback result, 10 Memory ALU result.
REQ-012 SHALL have ports StallF, StallD, StallE and StallM, output, 1 each, hold the stage register.
REQ-013 SHALL have ports FlushD, FlushE and FlushW, output, 1 each, load a bubble into the stage register.
REQ-014 SHALL have port MemErr, output, 1, sticky memory-timeout flag.
REQ-015 SHALL have ports StallCnt and FlushCnt, output, 32 each, performance counters.

Function
REQ-016 ForwardAE SHALL be 10 if RegWriteM, RdM!=0 and RdM==Rs1E; else 01 if RegWriteW, RdW!=0 and RdW==Rs1E; else 00. ForwardBE SHALL follow the same rule using Rs2E. Memory has priority over Writeback.
REQ-017 Load-use SHALL be detected when ResultSrcE==01, RdE!=0 and RdE equals Rs1D or Rs2D. It SHALL assert StallF, StallD and FlushE in the same cycle.
REQ-018 When PCSrcE=1, the block SHALL assert FlushD and FlushE. It SHALL clear the load-use StallF and StallD in that cycle.
REQ-019 The FSM SHALL have states RUN and MEM_WAIT.
REQ-020 RUN SHALL go to MEM_WAIT when MemReqM=1 and MemReadyM=0. MEM_WAIT SHALL return to RUN on the first cycle in which MemReadyM=1.
REQ-021 While MemReqM=1 and MemReadyM=0, in either state, the block SHALL assert StallF, StallD, StallE, StallM and FlushW. It SHALL hold FlushD and FlushE at 0 and suppress the load-use and branch actions.
REQ-022 A branch or load-use condition pending during a memory wait SHALL take effect combinationally in the cycle MemReadyM=1.
REQ-023 An 8-bit wait counter SHALL clear in RUN and increment each MEM_WAIT cycle. When it reaches MEM_TIMEOUT, MemErr SHALL set and stay set until reset; the counter SHALL saturate.
REQ-024 StallCnt SHALL increment by 1 in each cycle with StallF=1. FlushCnt SHALL increment by 1 in each cycle with FlushE=1. Both SHALL wrap modulo 2^32.
REQ-025 All forwarding, stall and flush outputs SHALL be combinational from the inputs and the FSM state, with zero-cycle latency.

Reset
REQ-026 While reset=1, the FSM SHALL go to RUN, the wait counter SHALL be 0, MemErr SHALL be 0, and StallCnt and FlushCnt SHALL be 0 on the next edge.
REQ-027 A reset asserted during MEM_WAIT SHALL return the FSM to RUN on the next edge.
REQ-028 While reset=1, all stall outputs SHALL be 0, and FlushD, FlushE and FlushW SHALL be 1.

Structure
REQ-029 The forward-select encodings, the FSM state enum and the RESULT_LOAD=2'b01 constant SHALL live in the shared package hazard_pkg.
REQ-030 Forwarding SHALL be implemented in one sub-module, fwd_unit, instantiated once per operand. All other logic SHALL be in hazard_ctrl.

Verification
REQ-031 Forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. With RdM=0 -> ForwardAE=01.
REQ-032 Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly one cycle; StallCnt increments by 1.
REQ-033 Branch with load-use: PCSrcE=1 together with the REQ-032 stimulus -> FlushD=FlushE=1, StallF=0; FlushCnt increments by 1.
REQ-034 Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> all four stalls and FlushW high for 3 cycles; a PCSrcE=1 held throughout flushes D and E only in the ready cycle.
REQ-035 Timeout: MEM_TIMEOUT=4, MemReadyM held at 0 -> MemErr=1 after the 4th wait cycle; it stays 1 after ready returns and clears only on reset.
REQ-036 Reset during MEM_WAIT -> the next cycle shows state RUN, counters 0, MemErr=0, FlushD=FlushE=FlushW=1 while reset is held.
